reg_scoreboard: RTL and testbench

Register-dependency scoreboard for the pipelined Y86-64 core, sitting between decode and the 15-entry register file. It records destinations (dstE/dstM) of issued instructions as pending and clears them when the matching write-back retires. It holds decode, through a valid/ready issue handshake, whenever a source register (srcA/srcB) or a destination counter is not safe to use. It is the read-side guard for the register file write port.

---
 rtl/reg_scoreboard.sv | 90 +++++++++
 tb/tb_reg_scoreboard.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-dependency scoreboard: one pending-write counter per Y86-64 register.
// It holds decode while a source is pending or a destination counter is full.
module reg_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [3:0]  issue_srcA,
  input  logic [3:0]  issue_srcB,
  input  logic [3:0]  issue_dstE,
  input  logic [3:0]  issue_dstM,
  input  logic        wb_valid,
  input  logic [3:0]  wb_dstE,
  input  logic [3:0]  wb_dstM,
  output logic [14:0] busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt      [15];
  logic [CNT_W-1:0] w_cnt_nxt  [15];
  logic             r_err;
  logic [14:0]      w_sat;
  logic [15:0]      w_pend;
  logic [15:0]      w_full;
  logic [14:0]      w_iset;
  logic [14:0]      w_wset;
  logic             w_fire;
  logic             w_uflow;

  always_comb begin
    busy  = '0;
    w_sat = '0;
    for (int unsigned r = 0; r < 15; r++) begin
      busy[r]  = |r_cnt[r];
      w_sat[r] = (r_cnt[r] == CNT_MAX);
    end
  end

  // Bit 15 stands for RNONE so that 0xF ids index a permanently clear slot.
  assign w_pend = {1'b0, busy};
  assign w_full = {1'b0, w_sat};

  assign issue_ready = Reset
                     & ~w_pend[issue_srcA] & ~w_pend[issue_srcB]
                     & ~w_full[issue_dstE] & ~w_full[issue_dstM];
  assign w_fire      = issue_valid & issue_ready;

  always_comb begin
    w_iset = '0;
    w_wset = '0;
    for (int unsigned r = 0; r < 15; r++) begin
      w_iset[r] = w_fire   && (issue_dstE == 4'(r) || issue_dstM == 4'(r));
      w_wset[r] = wb_valid && (wb_dstE    == 4'(r) || wb_dstM    == 4'(r));
    end
  end

  // A register both issued and retired in the same cycle keeps its count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_uflow   = 1'b0;
    for (int unsigned r = 0; r < 15; r++) begin
      if (w_iset[r] && !w_wset[r]) begin
        w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
      end else if (w_wset[r] && !w_iset[r]) begin
        if (r_cnt[r] == '0) begin
          w_uflow = 1'b1;
        end else begin
          w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '{default: '0};
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= r_err | w_uflow;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a per-register pending-count model is checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_srcA, issue_srcB, issue_dstE, issue_dstM;
  logic        wb_valid;
  logic [3:0]  wb_dstE, wb_dstM;
  logic [14:0] busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt [15];
  bit m_err;
  bit cmp_en = 1'b0;

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_srcA  (issue_srcA),
    .issue_srcB  (issue_srcB),
    .issue_dstE  (issue_dstE),
    .issue_dstM  (issue_dstM),
    .wb_valid    (wb_valid),
    .wb_dstE     (wb_dstE),
    .wb_dstM     (wb_dstM),
    .busy        (busy),
    .err         (err)
  );

  always #5 Clk = ~Clk;

  function automatic bit m_pend(input logic [3:0] id);
    if (id == 4'hF) return 1'b0;
    return m_cnt[id] != 0;
  endfunction

  function automatic bit m_full(input logic [3:0] id);
    if (id == 4'hF) return 1'b0;
    return m_cnt[id] == MAXC;
  endfunction

  function automatic bit m_ready();
    return Reset && !m_pend(issue_srcA) && !m_pend(issue_srcB)
                 && !m_full(issue_dstE) && !m_full(issue_dstM);
  endfunction

  function automatic logic [14:0] m_busy();
    logic [14:0] b;
    for (int r = 0; r < 15; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic m_clear();
    for (int r = 0; r < 15; r++) m_cnt[r] = 0;
    m_err = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("busy",  int'(busy),        int'(m_busy()));
      chk("err",   int'(err),         int'(m_err));
      chk("ready", int'(issue_ready), int'(m_ready()));
    end
  end

  // Hold one input vector across a rising edge, then advance the model.
  task automatic drive(input bit v, input logic [3:0] sA, input logic [3:0] sB,
                       input logic [3:0] dE, input logic [3:0] dM,
                       input bit wv, input logic [3:0] wE, input logic [3:0] wM);
    bit fire;
    issue_valid = v;  issue_srcA = sA; issue_srcB = sB;
    issue_dstE  = dE; issue_dstM = dM;
    wb_valid    = wv; wb_dstE    = wE; wb_dstM    = wM;
    fire = v && m_ready();
    @(posedge Clk);
    if (!Reset) begin
      m_clear();
    end else begin
      for (int r = 0; r < 15; r++) begin
        bit in_i, in_w;
        in_i = fire && (int'(dE) == r || int'(dM) == r);
        in_w = wv   && (int'(wE) == r || int'(wM) == r);
        if (in_i && !in_w) m_cnt[r]++;
        else if (in_w && !in_i) begin
          if (m_cnt[r] == 0) m_err = 1'b1;
          else m_cnt[r]--;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF);
  endtask

  task automatic issue(input logic [3:0] sA, input logic [3:0] dE, input logic [3:0] dM);
    drive(1'b1, sA, 4'hF, dE, dM, 1'b0, 4'hF, 4'hF);
  endtask

  task automatic wb(input logic [3:0] wE, input logic [3:0] wM);
    drive(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, wE, wM);
  endtask

  // Present ids without an edge so a literal ready expectation can be checked.
  task automatic present(input logic [3:0] sA, input logic [3:0] sB,
                         input logic [3:0] dE, input logic [3:0] dM);
    issue_valid = 1'b0; wb_valid = 1'b0;
    issue_srcA = sA; issue_srcB = sB; issue_dstE = dE; issue_dstM = dM;
    #1;
  endtask

  task automatic reset_pulse();
    Reset = 1'b0;
    m_clear();
    #1;
    chk("rst_async_busy",  int'(busy),        0);
    chk("rst_async_err",   int'(err),         0);
    chk("rst_async_ready", int'(issue_ready), 0);
    idle();
    idle();
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    issue_valid = 1'b0; wb_valid = 1'b0;
    issue_srcA = 4'hF; issue_srcB = 4'hF; issue_dstE = 4'hF; issue_dstM = 4'hF;
    wb_dstE = 4'hF; wb_dstM = 4'hF;
    m_clear();
    #2;
    cmp_en = 1'b1;
    idle(); idle();
    Reset = 1'b1;
    idle();

    present(4'h0, 4'h3, 4'hF, 4'hF);
    chk("idle_ready", int'(issue_ready), 1);
    chk("idle_busy",  int'(busy),        0);
    chk("idle_err",   int'(err),         0);

    // RAW on rax
    issue(4'hF, 4'h0, 4'hF);
    present(4'h0, 4'hF, 4'hF, 4'hF);
    chk("raw_ready", int'(issue_ready), 0);
    chk("raw_busy",  int'(busy),        32'h0001);
    drive(1'b1, 4'h0, 4'hF, 4'h5, 4'hF, 1'b1, 4'h0, 4'hF);
    present(4'h0, 4'hF, 4'hF, 4'hF);
    chk("raw_clear_ready", int'(issue_ready), 1);
    chk("raw_clear_busy",  int'(busy),        0);

    // Same-cycle issue and retire on r2
    issue(4'hF, 4'h2, 4'hF);
    drive(1'b1, 4'hF, 4'hF, 4'h2, 4'hF, 1'b1, 4'h2, 4'hF);
    chk("same_cyc_busy", int'(busy), 32'h0004);
    wb(4'h2, 4'hF);
    chk("same_cyc_clear", int'(busy), 0);

    // Saturation on r9
    issue(4'hF, 4'h9, 4'hF);
    issue(4'hF, 4'h9, 4'hF);
    issue(4'hF, 4'h9, 4'hF);
    chk("sat_model_cnt9", m_cnt[9], 3);
    present(4'hF, 4'hF, 4'h9, 4'hF);
    chk("sat_ready", int'(issue_ready), 0);
    issue(4'hF, 4'hF, 4'h9);
    chk("sat_blocked_cnt9", m_cnt[9], 3);
    wb(4'h9, 4'hF);
    present(4'hF, 4'hF, 4'h9, 4'hF);
    chk("sat_release_ready", int'(issue_ready), 1);
    wb(4'hF, 4'h9);
    wb(4'h9, 4'h9);
    chk("sat_drained_busy", int'(busy), 0);

    // popq %rsp
    issue(4'hF, 4'h4, 4'h4);
    chk("popq_busy", int'(busy), 32'h0010);
    wb(4'h4, 4'h4);
    chk("popq_clear_busy", int'(busy), 0);
    chk("popq_clear_err",  int'(err),  0);

    // RNONE and src/dst overlap; wb arriving during a hazard does not bypass
    issue(4'hF, 4'hF, 4'hF);
    chk("rnone_busy", int'(busy), 0);
    drive(1'b1, 4'h1, 4'h1, 4'h1, 4'hF, 1'b0, 4'hF, 4'hF);
    drive(1'b1, 4'h1, 4'hF, 4'h3, 4'hF, 1'b1, 4'h1, 4'hF);
    chk("overlap_busy", int'(busy), 0);
    issue(4'h1, 4'hE, 4'h3);
    chk("r14_busy", int'(busy), 32'h4008);
    wb(4'hE, 4'h3);

    // Underflow is sticky
    wb(4'h7, 4'hF);
    chk("uflow_err", int'(err), 1);
    idle(); idle();
    chk("uflow_sticky", int'(err), 1);

    // Reset discards pending entries; stale wb afterwards sets err
    issue(4'hF, 4'h1, 4'hF);
    issue(4'hF, 4'h1, 4'hF);
    chk("pre_rst_busy", int'(busy), 32'h0002);
    reset_pulse();
    idle();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_err",  int'(err),  0);
    wb(4'h1, 4'hF);
    chk("stale_wb_err", int'(err), 1);
    idle();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
